// File: rtl/sram_ctrl.sv
// Two-phase 16-bit SRAM controller serving 32-bit MEM-stage loads and stores.
// Define SRAM_CTRL_ADDR_CHECK_EN to reject out-of-range addresses with err.
module sram_ctrl #(
   parameter logic [31:0] BASE_ADDR     = 32'd1024,
   parameter int          ACCESS_CYCLES = 2,
   parameter int          SRAM_AW       = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic               err,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_o,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_i,
   output logic               sram_we_n
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int         WAW      = SRAM_AW - 1;
   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   logic [1:0]     state;
   logic [3:0]     cnt;
   logic [31:0]    addr_q;
   logic [31:0]    wdata_q;
   logic           wr_q;
   logic [WAW-1:0] word_idx;
   logic           req;
   logic           phase_end;
   logic           out_of_range;

   assign req       = rd_en | wr_en;
   assign phase_end = (cnt == LAST_CNT);
   // Only the low SRAM_AW-1 bits of the word index reach the pins.
   assign word_idx  = WAW'((addr_q - BASE_ADDR) >> 2);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
   logic [31:0] req_word_idx;
   logic        err_q;

   assign req_word_idx = (address - BASE_ADDR) >> 2;
   assign out_of_range = (address < BASE_ADDR) || ((req_word_idx >> WAW) != 32'd0);
   assign err          = err_q;

   // err is raised only for the DONE cycle of a rejected request.
   always_ff @(posedge clk) begin
      if (!rst)
         err_q <= 1'b0;
      else if (state == IDLE && req)
         err_q <= out_of_range;
      else if (state == DONE)
         err_q <= 1'b0;
   end
`else
   assign out_of_range = 1'b0;
   assign err          = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata   <= 32'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wr_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= address;
                  wdata_q <= wdata;
                  wr_q    <= wr_en;
                  cnt     <= 4'd0;
                  state   <= out_of_range ? DONE : LO;
               end
            end
            LO: begin
               if (phase_end) begin
                  if (!wr_q)
                     rdata[15:0] <= sram_dq_i;
                  cnt   <= 4'd0;
                  state <= HI;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            HI: begin
               if (phase_end) begin
                  if (!wr_q)
                     rdata[31:16] <= sram_dq_i;
                  cnt   <= 4'd0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   // Pad outputs are pure decodes of state so an abort idles them immediately.
   always_comb begin
      ready      = 1'b0;
      sram_addr  = '0;
      sram_dq_o  = 16'd0;
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
      case (state)
         IDLE: ready = !req;
         LO: begin
            sram_addr = {word_idx, 1'b0};
            if (wr_q) begin
               sram_dq_oe = 1'b1;
               sram_we_n  = 1'b0;
               sram_dq_o  = wdata_q[15:0];
            end
         end
         HI: begin
            sram_addr = {word_idx, 1'b1};
            if (wr_q) begin
               sram_dq_oe = 1'b1;
               sram_we_n  = 1'b0;
               sram_dq_o  = wdata_q[31:16];
            end
         end
         DONE: ready = 1'b1;
      endcase
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024: byte address that maps to SRAM halfword 0.
REQ-002 Parameter ACCESS_CYCLES, default 2, legal 1..15: cycles each 16-bit SRAM phase is held.
REQ-003 Parameter SRAM_AW, default 18: SRAM halfword address width.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 rd_en  input  1  MEM-stage load request; level, held until ready.
REQ-007 wr_en  input  1  MEM-stage store request; level, held until ready.
REQ-008 address  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data (Val_Rm).
REQ-010 rdata  output  32  load data; valid while ready=1 in DONE.
REQ-011 ready  output  1  0 = pipeline freeze; 1 = access complete or no access.
REQ-012 err  output  1  out-of-range access flag (see Configuration).
REQ-013 sram_addr  output  SRAM_AW  SRAM halfword address.
REQ-014 sram_dq_o  output  16  write data to pad.
REQ-015 sram_dq_oe  output  1  pad output enable.
REQ-016 sram_dq_i  input  16  read data from pad.
REQ-017 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-018 FSM states: IDLE, LO, HI, DONE, encoded in 2 bits.
REQ-019 IDLE: on an edge with rd_en|wr_en, latch address, wdata and op, clear phase counter, go to LO; otherwise stay.
REQ-020 Op is write when wr_en=1 (write priority when rd_en and wr_en are both 1), else read.
REQ-021 Word index w = (address - BASE_ADDR) >> 2, modulo 2^32; low 2 address bits ignored.
REQ-022 sram_addr = {w[SRAM_AW-2:0], 1'b0} in LO and {w[SRAM_AW-2:0], 1'b1} in HI; 0 in IDLE and DONE.
REQ-023 LO and HI: each lasts exactly ACCESS_CYCLES cycles, counted by a 4-bit counter that clears on phase entry.
REQ-024 Write in LO/HI: sram_dq_oe=1, sram_we_n=0, sram_dq_o = wdata[15:0] in LO and wdata[31:16] in HI.
REQ-025 Read in LO/HI: sram_dq_oe=0, sram_we_n=1; sram_dq_i is sampled on the last cycle of LO into rdata[15:0] and on the last cycle of HI into rdata[31:16].
REQ-026 Outside LO/HI: sram_we_n=1, sram_dq_oe=0, sram_dq_o=0.
REQ-027 DONE lasts one cycle with ready=1, then goes to IDLE unconditionally.
REQ-028 ready = !(rd_en|wr_en) in IDLE, 0 in LO/HI, 1 in DONE.
REQ-029 Latency: request seen in IDLE at cycle 0 -> ready=1 at cycle 2*ACCESS_CYCLES+1 (5 with the default).
REQ-030 Back-to-back requests: a request held after DONE starts a new access from IDLE one cycle later, with no lost cycle beyond IDLE.
REQ-031 rdata holds its last loaded value until overwritten by a read; writes do not alter rdata.
REQ-032 Inputs that change during LO/HI are ignored; the latched values govern the access.

Reset
REQ-033 While rst=0 at a clock edge: state goes to IDLE, counter=0, rdata=0, err=0, latched address/wdata/op=0.
REQ-034 Reset mid-access: the access aborts at the next edge; sram_we_n=1 and sram_dq_oe=0 from the following cycle; no partial rdata update occurs.

Configuration
REQ-035 Macro SRAM_CTRL_ADDR_CHECK_EN enables the address range check.
REQ-036 With the macro defined: a request with address < BASE_ADDR or w >= 2^(SRAM_AW-1) goes IDLE->DONE directly with no SRAM strobes, err=1 in DONE, and rdata unchanged.
REQ-037 With the macro undefined: no range check is performed, err is tied 0, and every request performs the full LO/HI sequence.

Verification
REQ-038 Store address=1024, wdata=32'hDEADBEEF, ACCESS_CYCLES=2 -> sram_addr=0 with dq_o=16'hBEEF for 2 cycles, then sram_addr=1 with dq_o=16'hDEAD for 2 cycles, ready=1 at cycle 5.
REQ-039 Load address=1028 with the SRAM model holding halfword 2=16'h5678 and halfword 3=16'h1234 -> rdata=32'h12345678 with ready=1 at cycle 5; sram_we_n stays 1 throughout.
REQ-040 rd_en=wr_en=1, address=1032 -> a write is performed to halfwords 4 and 5, and rdata is unchanged.
REQ-041 rst=0 at the second cycle of HI during a store -> IDLE next cycle with we_n=1, oe=0, ready=1 once rd_en and wr_en are low.
REQ-042 Two consecutive loads held with no gap, ACCESS_CYCLES=1 -> ready pulses at cycles 3 and 7, each for exactly one cycle.
REQ-043 With SRAM_CTRL_ADDR_CHECK_EN defined, load address=512 -> ready=1 and err=1 at cycle 1 with no SRAM activity; without the macro, the same load performs the full access and err=0.
